// File: rtl/wddl_xor_seq.sv
// Sequential dual-rail XOR reduction over one shared WDDL xor2 gate.
// Precharge/evaluate discipline and rail checks live here; the gate sits beside.
module wddl_xor2 #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a_p,
  input  logic [WIDTH-1:0] a_n,
  input  logic [WIDTH-1:0] b_p,
  input  logic [WIDTH-1:0] b_n,
  output logic [WIDTH-1:0] y_p,
  output logic [WIDTH-1:0] y_n
);
  assign y_p = (a_p & b_n) | (a_n & b_p);
  assign y_n = (a_p & b_p) | (a_n & b_n);
endmodule

module wddl_xor_seq #(
  parameter int WIDTH       = 8,
  parameter int NUM_OPS     = 6,
  parameter int PRE_CYCLES  = 1,
  parameter int EVAL_CYCLES = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_p,
  input  logic [WIDTH-1:0] in_n,
  output logic [WIDTH-1:0] xa_p,
  output logic [WIDTH-1:0] xa_n,
  output logic [WIDTH-1:0] xb_p,
  output logic [WIDTH-1:0] xb_n,
  input  logic [WIDTH-1:0] xy_p,
  input  logic [WIDTH-1:0] xy_n,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_p,
  output logic [WIDTH-1:0] out_n,
  output logic             err,
  input  logic             err_clr
);
  localparam int CW   = $clog2(NUM_OPS + 1);
  localparam int TMAX = (PRE_CYCLES > EVAL_CYCLES) ?
                        PRE_CYCLES : EVAL_CYCLES;
  localparam int TW   = $clog2(TMAX + 1);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_LOAD = 3'd1;
  localparam logic [2:0] S_PRE  = 3'd2;
  localparam logic [2:0] S_EVAL = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  localparam logic [CW-1:0] CNT_LAST  = CW'(NUM_OPS);
  localparam logic [TW-1:0] PRE_LAST  = TW'(PRE_CYCLES - 1);
  localparam logic [TW-1:0] EVAL_LAST = TW'(EVAL_CYCLES - 1);

  logic [2:0]       state_q, state_d;
  logic [WIDTH-1:0] acc_p_q, acc_p_d;
  logic [WIDTH-1:0] acc_n_q, acc_n_d;
  logic [WIDTH-1:0] op_p_q, op_p_d;
  logic [WIDTH-1:0] op_n_q, op_n_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [TW-1:0]    tmr_q, tmr_d;
  logic             err_q, err_d;

  logic             is_eval;
  logic             is_done;
  logic             accept;
  logic             bad_in;
  logic             pre_last;
  logic             eval_last;
  logic             pre_bad;
  logic             eval_bad;
  logic [CW-1:0]    cnt_inc;

  assign is_eval   = (state_q == S_EVAL);
  assign is_done   = (state_q == S_DONE);
  assign in_ready  = (state_q == S_IDLE) || (state_q == S_LOAD);
  assign accept    = in_valid && in_ready;
  assign bad_in    = accept && ((in_p ^ in_n) != '1);
  assign pre_last  = (state_q == S_PRE) && (tmr_q == PRE_LAST);
  assign eval_last = is_eval && (tmr_q == EVAL_LAST);
  assign pre_bad   = pre_last && (|(xy_p | xy_n));
  assign eval_bad  = eval_last && ((xy_p ^ xy_n) != '1);
  assign cnt_inc   = cnt_q + CW'(1);

  // gate inputs stay at spacer outside evaluation
  assign xa_p = is_eval ? acc_p_q : '0;
  assign xa_n = is_eval ? acc_n_q : '0;
  assign xb_p = is_eval ? op_p_q  : '0;
  assign xb_n = is_eval ? op_n_q  : '0;

  assign out_valid = is_done;
  assign out_p     = is_done ? acc_p_q : '0;
  assign out_n     = is_done ? acc_n_q : '0;
  assign err       = err_q;

  always_comb begin
    state_d = state_q;
    acc_p_d = acc_p_q;
    acc_n_d = acc_n_q;
    op_p_d  = op_p_q;
    op_n_d  = op_n_q;
    cnt_d   = cnt_q;
    tmr_d   = tmr_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          acc_p_d = in_p;
          acc_n_d = in_n;
          cnt_d   = CW'(1);
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        if (accept) begin
          op_p_d  = in_p;
          op_n_d  = in_n;
          tmr_d   = '0;
          state_d = S_PRE;
        end
      end
      S_PRE: begin
        if (pre_last) begin
          tmr_d   = '0;
          state_d = S_EVAL;
        end else begin
          tmr_d = tmr_q + TW'(1);
        end
      end
      S_EVAL: begin
        if (eval_last) begin
          acc_p_d = xy_p;
          acc_n_d = xy_n;
          cnt_d   = cnt_inc;
          state_d = (cnt_inc == CNT_LAST) ? S_DONE : S_LOAD;
        end else begin
          tmr_d = tmr_q + TW'(1);
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // a new violation outranks a clear in the same cycle
  always_comb begin
    err_d = err_q;
    if (bad_in || pre_bad || eval_bad) err_d = 1'b1;
    else if (err_clr)                  err_d = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      acc_p_q <= '0;
      acc_n_q <= '0;
      op_p_q  <= '0;
      op_n_q  <= '0;
      cnt_q   <= '0;
      tmr_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_p_q <= acc_p_d;
      acc_n_q <= acc_n_d;
      op_p_q  <= op_p_d;
      op_n_q  <= op_n_d;
      cnt_q   <= cnt_d;
      tmr_q   <= tmr_d;
      err_q   <= err_d;
    end
  end
endmodule
